pipeline_hazard_ctrl: RTL and testbench

Central stall/flush/forwarding controller for the 5-stage RV32IM pipeline. It generates per-stage hold and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC, and resolves four hazard classes: memory busywait, multi-cycle divide, taken branch/jump and load-use. It also drives the EX-stage operand forwarding selects and keeps saturating stall and flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 53 +++++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller
//               and the pipeline registers it steers.
//               - hz_state_t  : controller state (RUN / DIVWAIT)
//               - FWD_*       : EX operand forwarding select encodings
//               - ctrl_word_t : decoded control word carried down the pipe
//               - CTRL_NOP    : control word loaded when a register bubbles
//               - rd_match()  : "a pending write to rd feeds source rs" test
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller state. RUN is the normal issue state; DIVWAIT holds the
    // front of the pipe while a multi-cycle divide occupies EX.
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        DIVWAIT = 1'b1
    } hz_state_t;

    // EX operand source selects.
    localparam logic [1:0] FWD_RF    = 2'b00;  // register file value
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB write data

    // Decoded control word travelling with each instruction.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       div_op;
        logic [3:0] alu_op;
        logic       alu_src;
        logic [1:0] wb_sel;
    } ctrl_word_t;

    // A bubble clears every control bit so the slot has no side effects.
    localparam ctrl_word_t CTRL_NOP = '0;

    // True when a stage with write-enable 'we' and destination 'rd' produces
    // the value read through source 'rs'. x0 is hard-wired zero and is never
    // a real producer.
    function automatic logic rd_match(input logic       we,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Operand forwarding select for one EX source operand. The
//               younger producer (EX/MEM) wins over the older one (MEM/WB).
//               Purely combinational.
// Ports       : RS              in  5  source register read in EX
//               MEM_RD          in  5  destination held in EX/MEM
//               MEM_WRITEENABLE in  1  EX/MEM will write MEM_RD
//               WB_RD           in  5  destination held in MEM/WB
//               WB_WRITEENABLE  in  1  MEM/WB will write WB_RD
//               FWD_SEL         out 2  FWD_RF / FWD_EXMEM / FWD_MEMWB
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] RS,
    input  logic [4:0] MEM_RD,
    input  logic       MEM_WRITEENABLE,
    input  logic [4:0] WB_RD,
    input  logic       WB_WRITEENABLE,
    output logic [1:0] FWD_SEL
);

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = rd_match(MEM_WRITEENABLE, MEM_RD, RS);
    assign w_wb_hit  = rd_match(WB_WRITEENABLE, WB_RD, RS);

    always_comb begin
        FWD_SEL = FWD_RF;
        if (w_mem_hit) begin
            FWD_SEL = FWD_EXMEM;
        end else if (w_wb_hit) begin
            FWD_SEL = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall / flush / forwarding controller for the 5-stage RV32IM
//               pipeline. Produces hold and bubble controls for the PC and
//               the four pipeline registers, resolving (highest priority
//               first) memory busywait, multi-cycle divide, taken branch and
//               load-use hazards. Also drives EX forwarding selects and two
//               saturating performance counters.
// Parameters  : DIV_CYCLES  EX occupancy of a divide/remainder (>= 2)
//               CNT_W       performance counter width
// Ports       : CLK, RESET                    clock, sync active-high reset
//               IMEM_BUSYWAIT, DMEM_BUSYWAIT  cache wait requests
//               ID_RS1/RS2, ID_USES_RS1/RS2   sources of the ID instruction
//               EX_RS1/RS2/RD, EX_MEMREAD,
//               EX_DIV_START, BRANCH_TAKEN    EX instruction information
//               MEM_RD/WB_RD + WRITEENABLEs   pending register writes
//               PC/IF_ID/ID_EX/EX_MEM_HOLD    hold at the next edge
//               IF_ID_FLUSH, *_BUBBLE         load a NOP at the next edge
//               FWD_A_SEL, FWD_B_SEL          EX operand sources
//               DIV_BUSY                      EX held by a divide
//               STALL_CNT, FLUSH_CNT          saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IMEM_BUSYWAIT,
    input  logic             DMEM_BUSYWAIT,
    input  logic [4:0]       ID_RS1,
    input  logic [4:0]       ID_RS2,
    input  logic             ID_USES_RS1,
    input  logic             ID_USES_RS2,
    input  logic [4:0]       EX_RS1,
    input  logic [4:0]       EX_RS2,
    input  logic [4:0]       EX_RD,
    input  logic             EX_MEMREAD,
    input  logic             EX_DIV_START,
    input  logic             BRANCH_TAKEN,
    input  logic [4:0]       MEM_RD,
    input  logic [4:0]       WB_RD,
    input  logic             MEM_WRITEENABLE,
    input  logic             WB_WRITEENABLE,
    output logic             PC_HOLD,
    output logic             IF_ID_HOLD,
    output logic             ID_EX_HOLD,
    output logic             EX_MEM_HOLD,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_BUBBLE,
    output logic             EX_MEM_BUBBLE,
    output logic             MEM_WB_BUBBLE,
    output logic [1:0]       FWD_A_SEL,
    output logic [1:0]       FWD_B_SEL,
    output logic             DIV_BUSY,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    // The divide counter counts the remaining hold cycles after entry. Entry
    // itself is one hold cycle, so it starts at DIV_CYCLES-2 and the cycle in
    // which it reads zero is the release cycle.
    localparam int              DCNT_W    = $clog2(DIV_CYCLES);
    localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'(DIV_CYCLES - 2);

    hz_state_t          r_state;
    logic [DCNT_W-1:0]  r_dcnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic       w_busy;
    logic       w_load_use;
    logic       w_div_hold;
    logic       w_flush_evt;
    logic       w_pc_hold;
    logic       w_if_id_hold;
    logic       w_id_ex_hold;
    logic       w_ex_mem_hold;
    logic       w_if_id_flush;
    logic       w_id_ex_bubble;
    logic       w_ex_mem_bubble;
    logic       w_mem_wb_bubble;
    logic       w_div_busy;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_busy = IMEM_BUSYWAIT || DMEM_BUSYWAIT;

    // A load in EX whose destination is read by the ID instruction. The
    // rd != 0 qualifier lives inside rd_match().
    assign w_load_use = EX_MEMREAD &&
                        (rd_match(ID_USES_RS1, EX_RD, ID_RS1) ||
                         rd_match(ID_USES_RS2, EX_RD, ID_RS2));

    // ------------------------------------------------------------------
    // Hold / bubble generation. Combinational so the controls act on the
    // very next edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_div_hold      = 1'b0;
        w_flush_evt     = 1'b0;
        w_pc_hold       = 1'b0;
        w_if_id_hold    = 1'b0;
        w_id_ex_hold    = 1'b0;
        w_ex_mem_hold   = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_div_busy      = 1'b0;

        if (RESET) begin
            // Every register fills with NOPs while reset is held.
            w_if_id_flush   = 1'b1;
            w_id_ex_bubble  = 1'b1;
            w_ex_mem_bubble = 1'b1;
            w_mem_wb_bubble = 1'b1;
        end else if (w_busy) begin
            // Freeze the whole front end; WB retires a NOP meanwhile so the
            // instruction in MEM/WB is not written back twice.
            w_pc_hold       = 1'b1;
            w_if_id_hold    = 1'b1;
            w_id_ex_hold    = 1'b1;
            w_ex_mem_hold   = 1'b1;
            w_mem_wb_bubble = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (EX_DIV_START) begin
                        // Divide outranks a simultaneous taken branch.
                        w_div_hold = 1'b1;
                    end else if (BRANCH_TAKEN) begin
                        // Squash the two wrong-path slots; a load-use match
                        // against a squashed instruction is irrelevant.
                        w_flush_evt    = 1'b1;
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_hold      = 1'b1;
                        w_if_id_hold   = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end
                end
                DIVWAIT: begin
                    // dcnt == 0 is the release cycle: nothing asserted, the
                    // divide result moves into EX/MEM at this edge.
                    w_div_hold = (r_dcnt != '0);
                end
                default: begin
                    w_div_hold = 1'b0;
                end
            endcase

            if (w_div_hold) begin
                w_pc_hold       = 1'b1;
                w_if_id_hold    = 1'b1;
                w_id_ex_hold    = 1'b1;
                w_ex_mem_bubble = 1'b1;
                w_div_busy      = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Divide state machine.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= RUN;
            r_dcnt  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    // A divide cannot start while a busywait freezes EX.
                    if (!w_busy && EX_DIV_START) begin
                        r_state <= DIVWAIT;
                        r_dcnt  <= DCNT_INIT;
                    end
                end
                DIVWAIT: begin
                    // The divider keeps iterating under busywait, so only the
                    // release cycle can be stretched by it.
                    if (r_dcnt != '0) begin
                        r_dcnt <= r_dcnt - DCNT_W'(1);
                    end else if (!w_busy) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_dcnt  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_pc_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding, one unit per EX operand. Independent of stall state;
    // only reset forces the register-file source.
    // ------------------------------------------------------------------
    fwd_unit u_fwd_a (
        .RS              (EX_RS1),
        .MEM_RD          (MEM_RD),
        .MEM_WRITEENABLE (MEM_WRITEENABLE),
        .WB_RD           (WB_RD),
        .WB_WRITEENABLE  (WB_WRITEENABLE),
        .FWD_SEL         (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .RS              (EX_RS2),
        .MEM_RD          (MEM_RD),
        .MEM_WRITEENABLE (MEM_WRITEENABLE),
        .WB_RD           (WB_RD),
        .WB_WRITEENABLE  (WB_WRITEENABLE),
        .FWD_SEL         (w_fwd_b)
    );

    assign PC_HOLD       = w_pc_hold;
    assign IF_ID_HOLD    = w_if_id_hold;
    assign ID_EX_HOLD    = w_id_ex_hold;
    assign EX_MEM_HOLD   = w_ex_mem_hold;
    assign IF_ID_FLUSH   = w_if_id_flush;
    assign ID_EX_BUBBLE  = w_id_ex_bubble;
    assign EX_MEM_BUBBLE = w_ex_mem_bubble;
    assign MEM_WB_BUBBLE = w_mem_wb_bubble;
    assign DIV_BUSY      = w_div_busy;
    assign FWD_A_SEL     = RESET ? FWD_RF : w_fwd_a;
    assign FWD_B_SEL     = RESET ? FWD_RF : w_fwd_b;
    assign STALL_CNT     = r_stall_cnt;
    assign FLUSH_CNT     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. A cycle-level
//               behavioural model (divide tracked by its age since start)
//               checks every output on every cycle; directed sequences pin
//               the model with literal expectations, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int DIV_CYCLES = 12;
    localparam int CNT_W      = 8;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             IMEM_BUSYWAIT, DMEM_BUSYWAIT;
    logic [4:0]       ID_RS1, ID_RS2, EX_RS1, EX_RS2, EX_RD, MEM_RD, WB_RD;
    logic             ID_USES_RS1, ID_USES_RS2, EX_MEMREAD, EX_DIV_START;
    logic             BRANCH_TAKEN, MEM_WRITEENABLE, WB_WRITEENABLE;
    logic             PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD;
    logic             IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE, MEM_WB_BUBBLE;
    logic [1:0]       FWD_A_SEL, FWD_B_SEL;
    logic             DIV_BUSY;
    logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
        .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD),
        .EX_MEMREAD(EX_MEMREAD), .EX_DIV_START(EX_DIV_START),
        .BRANCH_TAKEN(BRANCH_TAKEN),
        .MEM_RD(MEM_RD), .WB_RD(WB_RD),
        .MEM_WRITEENABLE(MEM_WRITEENABLE), .WB_WRITEENABLE(WB_WRITEENABLE),
        .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD),
        .ID_EX_HOLD(ID_EX_HOLD), .EX_MEM_HOLD(EX_MEM_HOLD),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_BUBBLE(ID_EX_BUBBLE),
        .EX_MEM_BUBBLE(EX_MEM_BUBBLE), .MEM_WB_BUBBLE(MEM_WB_BUBBLE),
        .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
        .DIV_BUSY(DIV_BUSY), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the divide is described by its age in cycles since
    // it was accepted. It holds while age <= DIV_CYCLES-2 and leaves EX in
    // the first non-busywait cycle after that.
    // ------------------------------------------------------------------
    bit m_in_div = 1'b0;
    int m_age    = 0;
    int m_stall  = 0;
    int m_flush  = 0;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (MEM_WRITEENABLE && MEM_RD != 0 && MEM_RD == rs) return 2'b01;
        if (WB_WRITEENABLE && WB_RD != 0 && WB_RD == rs)    return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge CLK) begin : model
        logic busy, lu, br_fire, div_hold;
        logic e_pc, e_ifh, e_idh, e_exh, e_iff, e_idb, e_exb, e_mwb, e_db;
        logic [1:0] e_fa, e_fb;
        {e_pc, e_ifh, e_idh, e_exh, e_iff, e_idb, e_exb, e_mwb, e_db} = '0;
        br_fire  = 1'b0;
        div_hold = 1'b0;
        busy = IMEM_BUSYWAIT || DMEM_BUSYWAIT;
        lu = EX_MEMREAD && EX_RD != 0 &&
             ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
        if (RESET) begin
            {e_iff, e_idb, e_exb, e_mwb} = 4'b1111;
        end else if (busy) begin
            {e_pc, e_ifh, e_idh, e_exh, e_mwb} = 5'b11111;
        end else if (m_in_div) begin
            div_hold = (m_age <= DIV_CYCLES - 2);
        end else if (EX_DIV_START) begin
            div_hold = 1'b1;
        end else if (BRANCH_TAKEN) begin
            e_iff = 1'b1; e_idb = 1'b1; br_fire = 1'b1;
        end else if (lu) begin
            e_pc = 1'b1; e_ifh = 1'b1; e_idb = 1'b1;
        end
        if (div_hold) begin
            e_pc = 1'b1; e_ifh = 1'b1; e_idh = 1'b1; e_exb = 1'b1; e_db = 1'b1;
        end
        e_fa = RESET ? 2'b00 : ref_fwd(EX_RS1);
        e_fb = RESET ? 2'b00 : ref_fwd(EX_RS2);

        chk("pc_hold", PC_HOLD, e_pc);
        chk("if_id_hold", IF_ID_HOLD, e_ifh);
        chk("id_ex_hold", ID_EX_HOLD, e_idh);
        chk("ex_mem_hold", EX_MEM_HOLD, e_exh);
        chk("if_id_flush", IF_ID_FLUSH, e_iff);
        chk("id_ex_bubble", ID_EX_BUBBLE, e_idb);
        chk("ex_mem_bubble", EX_MEM_BUBBLE, e_exb);
        chk("mem_wb_bubble", MEM_WB_BUBBLE, e_mwb);
        chk("div_busy", DIV_BUSY, e_db);
        chk("fwd_a", FWD_A_SEL, e_fa);
        chk("fwd_b", FWD_B_SEL, e_fb);
        chk("stall_cnt", STALL_CNT, m_stall);
        chk("flush_cnt", FLUSH_CNT, m_flush);

        // Effect of the upcoming edge.
        if (RESET) begin
            m_in_div = 1'b0; m_age = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_in_div) begin
                if (m_age >= DIV_CYCLES - 1 && !busy) m_in_div = 1'b0;
                m_age++;
            end else if (!busy && EX_DIV_START) begin
                m_in_div = 1'b1;
                m_age    = 1;
            end
            if (e_pc && m_stall < CNT_MAX) m_stall++;
            if (br_fire && m_flush < CNT_MAX) m_flush++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after posedge, literal
    // checks happen on the following negedge.
    // ------------------------------------------------------------------
    task automatic to_drive();
        @(posedge CLK); #1;
    endtask

    task automatic to_sample();
        @(negedge CLK);
    endtask

    task automatic clr();
        IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0;
        ID_RS1 = 0; ID_RS2 = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
        EX_RS1 = 0; EX_RS2 = 0; EX_RD = 0; EX_MEMREAD = 0;
        EX_DIV_START = 0; BRANCH_TAKEN = 0;
        MEM_RD = 0; WB_RD = 0; MEM_WRITEENABLE = 0; WB_WRITEENABLE = 0;
    endtask

    initial begin
        RESET = 1'b1;
        clr();
        EX_RS1 = 5'd7; MEM_RD = 5'd7; MEM_WRITEENABLE = 1'b1;
        to_sample();
        chk("rst_if_id_flush", IF_ID_FLUSH, 1);
        chk("rst_mem_wb_bubble", MEM_WB_BUBBLE, 1);
        chk("rst_ex_mem_bubble", EX_MEM_BUBBLE, 1);
        chk("rst_pc_hold", PC_HOLD, 0);
        chk("rst_fwd_a", FWD_A_SEL, 0);

        to_drive(); RESET = 1'b0; clr();
        to_sample();
        chk("idle_stall_cnt", STALL_CNT, 0);
        chk("idle_flush_cnt", FLUSH_CNT, 0);

        // Load-use on rs2.
        to_drive(); EX_MEMREAD = 1; EX_RD = 5; ID_RS2 = 5; ID_USES_RS2 = 1;
        to_sample();
        chk("lu_pc_hold", PC_HOLD, 1);
        chk("lu_if_id_hold", IF_ID_HOLD, 1);
        chk("lu_id_ex_bubble", ID_EX_BUBBLE, 1);
        chk("lu_id_ex_hold", ID_EX_HOLD, 0);
        to_drive(); clr();
        to_sample();
        chk("lu_after_pc_hold", PC_HOLD, 0);
        chk("lu_stall_cnt", STALL_CNT, 1);
        to_drive(); EX_MEMREAD = 1; EX_RD = 0; ID_RS2 = 0; ID_USES_RS2 = 1;
        to_sample();
        chk("lu_x0_pc_hold", PC_HOLD, 0);

        // Taken branch beats load-use.
        to_drive(); clr();
        EX_MEMREAD = 1; EX_RD = 5; ID_RS1 = 5; ID_USES_RS1 = 1; BRANCH_TAKEN = 1;
        to_sample();
        chk("br_if_id_flush", IF_ID_FLUSH, 1);
        chk("br_id_ex_bubble", ID_EX_BUBBLE, 1);
        chk("br_pc_hold", PC_HOLD, 0);
        to_drive(); clr();
        to_sample();
        chk("br_flush_cnt", FLUSH_CNT, 1);
        chk("br_stall_cnt", STALL_CNT, 1);

        // Forwarding priority.
        to_drive(); EX_RS1 = 7; MEM_RD = 7; MEM_WRITEENABLE = 1; WB_RD = 7; WB_WRITEENABLE = 1;
        to_sample();
        chk("fwd_a_exmem", FWD_A_SEL, 2'b01);
        chk("fwd_b_rf", FWD_B_SEL, 2'b00);
        to_drive(); MEM_WRITEENABLE = 0;
        to_sample();
        chk("fwd_a_memwb", FWD_A_SEL, 2'b10);
        to_drive(); EX_RS1 = 0; EX_RS2 = 7;
        to_sample();
        chk("fwd_a_x0", FWD_A_SEL, 2'b00);
        chk("fwd_b_memwb", FWD_B_SEL, 2'b10);

        // Plain divide: busy for DIV_CYCLES-1 cycles, then release.
        to_drive(); clr(); EX_DIV_START = 1;
        for (int k = 0; k < DIV_CYCLES; k++) begin
            if (k > 0) to_drive();
            to_sample();
            chk("div_busy_seq", DIV_BUSY, (k <= DIV_CYCLES - 2) ? 1 : 0);
        end
        to_drive(); clr(); BRANCH_TAKEN = 1;
        to_sample();
        chk("div_back_in_run", IF_ID_FLUSH, 1);
        to_drive(); clr();
        to_sample();
        chk("div_stall_cnt", STALL_CNT, 1 + (DIV_CYCLES - 1));
        chk("div_flush_cnt", FLUSH_CNT, 2);

        // DMEM busywait across the end of a divide stretches the release.
        to_drive(); clr(); EX_DIV_START = 1;
        for (int k = 0; k <= DIV_CYCLES + 2; k++) begin
            if (k > 0) to_drive();
            DMEM_BUSYWAIT = (k >= 2 && k <= DIV_CYCLES + 1);
            to_sample();
            if (k >= 2 && k <= DIV_CYCLES + 1) begin
                chk("bw_div_ex_mem_hold", EX_MEM_HOLD, 1);
                chk("bw_div_mem_wb_bubble", MEM_WB_BUBBLE, 1);
            end
        end
        chk("bw_div_release_pc_hold", PC_HOLD, 0);
        chk("bw_div_release_busy", DIV_BUSY, 0);
        to_drive(); clr(); BRANCH_TAKEN = 1;
        to_sample();
        chk("bw_div_back_in_run", IF_ID_FLUSH, 1);

        // Reset in the middle of a divide.
        to_drive(); clr(); EX_DIV_START = 1;
        to_sample();
        to_drive(); RESET = 1;
        to_sample();
        chk("rst_div_busy", DIV_BUSY, 0);
        chk("rst_div_id_ex_bubble", ID_EX_BUBBLE, 1);
        chk("rst_div_pc_hold", PC_HOLD, 0);
        to_drive(); RESET = 0; EX_DIV_START = 0; BRANCH_TAKEN = 1;
        to_sample();
        chk("rst_div_run", IF_ID_FLUSH, 1);
        chk("rst_div_stall_cnt", STALL_CNT, 0);
        chk("rst_div_flush_cnt", FLUSH_CNT, 0);

        // Stall counter saturation.
        to_drive(); clr(); IMEM_BUSYWAIT = 1;
        repeat (CNT_MAX + 4) to_drive();
        to_sample();
        chk("sat_stall_cnt", STALL_CNT, CNT_MAX);
        to_drive();
        to_sample();
        chk("sat_stall_cnt_hold", STALL_CNT, CNT_MAX);

        // Random traffic against the model.
        repeat (4000) begin
            to_drive();
            RESET           = ($urandom_range(0, 99) < 2);
            IMEM_BUSYWAIT   = ($urandom_range(0, 99) < 8);
            DMEM_BUSYWAIT   = ($urandom_range(0, 99) < 8);
            ID_RS1          = 5'($urandom_range(0, 3));
            ID_RS2          = 5'($urandom_range(0, 3));
            ID_USES_RS1     = 1'($urandom);
            ID_USES_RS2     = 1'($urandom);
            EX_RS1          = 5'($urandom_range(0, 3));
            EX_RS2          = 5'($urandom_range(0, 3));
            EX_RD           = 5'($urandom_range(0, 3));
            EX_MEMREAD      = ($urandom_range(0, 99) < 35);
            EX_DIV_START    = ($urandom_range(0, 99) < 5);
            BRANCH_TAKEN    = ($urandom_range(0, 99) < 20);
            MEM_RD          = 5'($urandom_range(0, 3));
            WB_RD           = 5'($urandom_range(0, 3));
            MEM_WRITEENABLE = 1'($urandom);
            WB_WRITEENABLE  = 1'($urandom);
        end
        to_drive(); RESET = 0; clr();
        to_sample();
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
